// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared encodings and layout constants for the debug trace block
package dbg_pkg;

  localparam int DBG_PROBE_BW = 119;
  localparam int DBG_LA_BW    = 128;

  typedef enum logic [1:0] {
    DBG_MODE_LIVE   = 2'd0,
    DBG_MODE_FREEZE = 2'd1,
    DBG_MODE_TRACE  = 2'd2,
    DBG_MODE_STATUS = 2'd3
  } dbg_mode_e;

  typedef enum logic [1:0] {
    DBG_ST_IDLE    = 2'd0,
    DBG_ST_ARMED   = 2'd1,
    DBG_ST_CAPTURE = 2'd2,
    DBG_ST_DONE    = 2'd3
  } dbg_state_e;

  localparam int DBG_TRIG_CNT_BW = 16;
  localparam int DBG_ST_WR_LSB   = 2;

  function automatic int dbg_st_rd_lsb(input int aw);
    return aw + 3;
  endfunction

  function automatic int dbg_st_trig_lsb(input int aw);
    return 2 * aw + 3;
  endfunction

  // Where each pipeline stage lands in the packed probe vector
  localparam int DBG_CTL_BIT     = 0;
  localparam int DBG_MIC_BIT     = 1;
  localparam int DBG_DFE_LSB     = 2;
  localparam int DBG_DFE_MSB     = 9;
  localparam int DBG_DFE_VLD_BIT = 10;
  localparam int DBG_ACO_LSB     = 11;
  localparam int DBG_ACO_MSB     = 114;
  localparam int DBG_ACO_B0_BIT  = 115;
  localparam int DBG_ACO_B1_BIT  = 116;
  localparam int DBG_WRD_B0_BIT  = 117;
  localparam int DBG_WRD_B1_BIT  = 118;

endpackage

// File: rtl/dbg_trace_buf.sv
// rtl/dbg_trace_buf.sv - trace storage: flop array, one write port, async read, reset to zero
module dbg_trace_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 119,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dbg_trace.sv
// rtl/dbg_trace.sv - LA probe override plus triggered, decimated trace capture
module dbg_trace
  import dbg_pkg::*;
#(
  parameter  int PROBE_BW = DBG_PROBE_BW,
  parameter  int LA_BW    = DBG_LA_BW,
  parameter  int DEPTH    = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [LA_BW-1:0]    la_data_in_i,
  input  logic [LA_BW-1:0]    la_oenb_i,
  output logic [LA_BW-1:0]    la_data_out_o,
  input  logic [PROBE_BW-1:0] probe_i,
  output logic [PROBE_BW-1:0] probe_o,
  input  logic [1:0]          cfg_mode_i,
  input  logic                cfg_arm_i,
  input  logic                cfg_rd_i,
  input  logic [7:0]          cfg_div_i,
  input  logic [PROBE_BW-1:0] trig_mask_i,
  input  logic [PROBE_BW-1:0] trig_value_i,
  output logic                done_o
);

  localparam int          ST_RD_LSB   = dbg_st_rd_lsb(AW);
  localparam int          ST_TRIG_LSB = dbg_st_trig_lsb(AW);
  localparam logic [AW:0] WR_FULL     = (AW+1)'(DEPTH);

  dbg_state_e                      state_q, state_d;
  logic [AW:0]                     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [DBG_TRIG_CNT_BW-1:0]      trig_cnt_q, trig_cnt_d;
  logic [7:0]                      div_q, div_d, div_cnt_q, div_cnt_d;
  logic [PROBE_BW-1:0]             snap_q, snap_d;
  logic                            buf_we;
  logic [AW-1:0]                   buf_waddr;
  logic [PROBE_BW-1:0]             buf_rdata;
  logic                            match;
  logic [LA_BW-1:0]                status;

  assign probe_o = (la_oenb_i[PROBE_BW-1:0] & probe_i) |
                   (~la_oenb_i[PROBE_BW-1:0] & la_data_in_i[PROBE_BW-1:0]);

  generate
    if (LA_BW > PROBE_BW) begin : g_la_spare
      logic unused_la_spare;
      assign unused_la_spare = ^{la_data_in_i[LA_BW-1:PROBE_BW], la_oenb_i[LA_BW-1:PROBE_BW]};
    end
  endgenerate

  assign match  = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  assign done_o = (state_q == DBG_ST_DONE);

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    trig_cnt_d = trig_cnt_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    snap_d     = snap_q;
    buf_we     = 1'b0;
    buf_waddr  = wr_cnt_q[AW-1:0];
    // Arm overrides everything, including a read pulse or a match in the same cycle
    if (cfg_arm_i) begin
      state_d   = DBG_ST_ARMED;
      wr_cnt_d  = '0;
      rd_ptr_d  = '0;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        DBG_ST_ARMED: begin
          if (match) begin
            state_d   = DBG_ST_CAPTURE;
            snap_d    = probe_i;
            buf_we    = 1'b1;
            buf_waddr = '0;
            wr_cnt_d  = (AW+1)'(1);
            div_d     = cfg_div_i;
            div_cnt_d = '0;
            if (trig_cnt_q != '1) trig_cnt_d = trig_cnt_q + 1'b1;
          end
        end
        DBG_ST_CAPTURE: begin
          if (div_cnt_q == div_q) begin
            buf_we    = 1'b1;
            wr_cnt_d  = wr_cnt_q + 1'b1;
            div_cnt_d = '0;
            if (wr_cnt_d == WR_FULL) state_d = DBG_ST_DONE;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        DBG_ST_DONE: begin
          if (cfg_rd_i) rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= DBG_ST_IDLE;
      wr_cnt_q   <= '0;
      rd_ptr_q   <= '0;
      trig_cnt_q <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      trig_cnt_q <= trig_cnt_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      snap_q     <= snap_d;
    end
  end

  dbg_trace_buf #(.DEPTH(DEPTH), .W(PROBE_BW), .AW(AW)) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (probe_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    status                                = '0;
    status[1:0]                           = state_q;
    status[DBG_ST_WR_LSB +: AW+1]         = wr_cnt_q;
    status[ST_RD_LSB +: AW]               = rd_ptr_q;
    status[ST_TRIG_LSB +: DBG_TRIG_CNT_BW] = trig_cnt_q;
  end

  always_comb begin
    la_data_out_o = '0;
    case (dbg_mode_e'(cfg_mode_i))
      DBG_MODE_LIVE:   la_data_out_o[PROBE_BW-1:0] = probe_i;
      DBG_MODE_FREEZE: la_data_out_o[PROBE_BW-1:0] = snap_q;
      DBG_MODE_TRACE:  la_data_out_o[PROBE_BW-1:0] = buf_rdata;
      DBG_MODE_STATUS: la_data_out_o               = status;
      default:         la_data_out_o               = '0;
    endcase
  end

endmodule

// File: tb/tb_dbg_trace.sv
// tb/tb_dbg_trace.sv - scoreboard bench for dbg_trace: override, capture, decimation, re-arm, reset
module tb_dbg_trace;

  localparam int PBW   = 119;
  localparam int LBW   = 128;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [LBW-1:0] la_data_in, la_oenb, la_data_out;
  logic [PBW-1:0] probe, probe_out, trig_mask, trig_value;
  logic [1:0]     mode;
  logic           arm, rd, done;
  logic [7:0]     div;

  int             n_assert = 0;
  int             n_fail   = 0;
  logic [LBW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dbg_trace #(.PROBE_BW(PBW), .LA_BW(LBW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .la_data_in_i  (la_data_in),
    .la_oenb_i     (la_oenb),
    .la_data_out_o (la_data_out),
    .probe_i       (probe),
    .probe_o       (probe_out),
    .cfg_mode_i    (mode),
    .cfg_arm_i     (arm),
    .cfg_rd_i      (rd),
    .cfg_div_i     (div),
    .trig_mask_i   (trig_mask),
    .trig_value_i  (trig_value),
    .done_o        (done)
  );

  task automatic chk(input string tag, input logic [LBW-1:0] got, input logic [LBW-1:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LBW-1:0] status_word(input int st, input int wr, input int rp, input int tc);
    logic [LBW-1:0] w;
    w        = '0;
    w[1:0]   = st[1:0];
    w[6:2]   = wr[4:0];
    w[10:7]  = rp[3:0];
    w[26:11] = tc[15:0];
    return w;
  endfunction

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    nxt();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();
  endtask

  // Arms, triggers on base, then drives base+n on the n-th edge after the trigger.
  task automatic run_trace(input logic [7:0] d, input logic [PBW-1:0] base, output int lat);
    int pushed;
    trig_mask  = PBW'(3);
    trig_value = PBW'(1);
    div        = d;
    probe      = '0;
    arm        = 1'b1;
    nxt();
    arm = 1'b0;
    exp_q.delete();
    pushed = 0;
    lat    = -1;
    for (int n = 0; n < 2000; n++) begin
      probe = base + PBW'(n);
      if ((n % (int'(d) + 1)) == 0 && pushed < DEPTH) begin
        exp_q.push_back(LBW'(probe));
        pushed++;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    nxt();
  endtask

  task automatic read_trace(input string tag, input logic [LBW-1:0] first);
    logic [LBW-1:0] e;
    mode = 2'd2;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk(tag, la_data_out, e);
      pulse_rd();
    end
    #1;
    chk({tag, "_wrap"}, la_data_out, first);
  endtask

  initial begin
    logic [PBW-1:0] r;
    int             lat;

    rst_n      = 1'b0;
    la_data_in = '0;
    la_oenb    = '1;
    probe      = '0;
    mode       = 2'd3;
    arm        = 1'b0;
    rd         = 1'b0;
    div        = '0;
    trig_mask  = '0;
    trig_value = '0;

    nxt();
    #1;
    chk("rst_status", la_data_out, '0);
    chk("rst_done", LBW'(done), '0);
    rst_n = 1'b1;
    nxt();
    mode = 2'd1;
    #1;
    chk("rst_freeze", la_data_out, '0);
    mode = 2'd2;
    #1;
    chk("rst_trace", la_data_out, '0);

    // Override
    r     = PBW'({$urandom, $urandom, $urandom, $urandom});
    probe = r;
    #1;
    chk("ovr_pass", LBW'(probe_out), LBW'(r));
    mode = 2'd0;
    #1;
    chk("live", la_data_out, LBW'(r));
    la_oenb[0]      = 1'b0;
    la_oenb[LBW-1]  = 1'b0;
    la_data_in[0]   = 1'b1;
    la_data_in[LBW-1] = 1'b1;
    probe[0]        = 1'b0;
    #1;
    chk("ovr_bit0", LBW'(probe_out), LBW'({r[PBW-1:1], 1'b1}));
    chk("live_pre_ovr", la_data_out, LBW'({r[PBW-1:1], 1'b0}));
    la_oenb    = '1;
    la_data_in = '0;
    nxt();

    // Basic trace, no decimation
    do_reset();
    run_trace(8'd0, PBW'(32'h11), lat);
    chk("done_lat_div0", LBW'(lat), LBW'(15));
    mode = 2'd3;
    #1;
    chk("status_div0", la_data_out, status_word(3, 16, 0, 1));
    read_trace("trace_div0", LBW'(32'h11));

    // Decimation by 4
    do_reset();
    run_trace(8'd3, PBW'(32'h101), lat);
    chk("done_lat_div3", LBW'(lat), LBW'(60));
    mode = 2'd3;
    #1;
    chk("status_div3", la_data_out, status_word(3, 16, 0, 1));
    read_trace("trace_div3", LBW'(32'h101));

    // Freeze
    do_reset();
    trig_mask  = PBW'(32'hFF);
    trig_value = PBW'(32'h5A);
    div        = 8'd0;
    probe      = '0;
    arm        = 1'b1;
    nxt();
    arm   = 1'b0;
    probe = PBW'(32'h5A);
    nxt();
    probe = PBW'(32'h77);
    mode  = 2'd1;
    #1;
    chk("freeze_hold", la_data_out, LBW'(32'h5A));
    mode = 2'd0;
    #1;
    chk("live_track", la_data_out, LBW'(32'h77));
    r     = PBW'({$urandom, $urandom, $urandom, $urandom});
    probe = r;
    #1;
    chk("live_track_rnd", la_data_out, LBW'(r));
    mode = 2'd1;
    #1;
    chk("freeze_hold_rnd", la_data_out, LBW'(32'h5A));
    for (int i = 0; i < 40 && !done; i++) nxt();
    chk("freeze_done", LBW'(done), LBW'(1));

    // Re-arm together with read, match during arm cycle
    pulse_rd();
    pulse_rd();
    mode = 2'd3;
    #1;
    chk("rd_adv", la_data_out, status_word(3, 16, 2, 1));
    arm   = 1'b1;
    rd    = 1'b1;
    probe = PBW'(32'h5A);
    nxt();
    arm   = 1'b0;
    probe = '0;
    #1;
    chk("arm_wins", la_data_out, status_word(1, 0, 0, 1));
    chk("arm_done_low", LBW'(done), '0);
    nxt();
    rd    = 1'b0;
    probe = PBW'(32'h5A);
    #1;
    chk("rd_in_armed", la_data_out, status_word(1, 0, 0, 1));
    nxt();
    #1;
    chk("trig_after_arm", la_data_out, status_word(2, 1, 0, 2));

    // Asynchronous reset mid-capture
    for (int i = 0; i < 6; i++) nxt();
    #1;
    chk("wr_cnt7", la_data_out, status_word(2, 7, 0, 2));
    rst_n = 1'b0;
    #1;
    chk("arst_status", la_data_out, '0);
    chk("arst_done", LBW'(done), '0);
    mode = 2'd2;
    #1;
    chk("arst_trace", la_data_out, '0);
    mode = 2'd1;
    #1;
    chk("arst_freeze", la_data_out, '0);
    nxt();
    rst_n = 1'b1;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_trace.md
Name: dbg_trace

Overview:
- Next-generation debug block between the pipeline stages (ctl, mic, dfe, aco, wrd) and the Caravel logic analyzer.
- Keeps per-bit LA override of a packed probe vector.
- Adds a triggered trace buffer: the LA can observe live, frozen or stored probe data plus a status word.
- Probe vector, LA width and trace depth are parametrised.

Parameters:
PROBE_BW, 119, width of packed probe vector (must be <= LA_BW)
LA_BW, 128, logic analyzer width
DEPTH, 16, trace buffer entries (power of two, >= 2)
AW, $clog2(DEPTH), trace pointer width (derived, not overridden)

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
la_data_in_i  input  LA_BW  LA override values
la_oenb_i  input  LA_BW  per-bit override enable, active-low (0 = LA drives)
la_data_out_o  output  LA_BW  observed data to LA
probe_i  input  PROBE_BW  packed pipeline signals
probe_o  output  PROBE_BW  muxed signals back to pipeline
cfg_mode_i  input  2  LA view: 0 LIVE, 1 FREEZE, 2 TRACE, 3 STATUS
cfg_arm_i  input  1  single-cycle pulse; arms capture
cfg_rd_i  input  1  single-cycle pulse; advances trace read pointer
cfg_div_i  input  8  decimation: one sample every cfg_div_i+1 cycles
trig_mask_i  input  PROBE_BW  trigger compare mask
trig_value_i  input  PROBE_BW  trigger compare value
done_o  output  1  high while state == DONE

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (rst_n_i).
- Override (combinational, zero latency), per bit i < PROBE_BW: probe_o[i] = la_oenb_i[i] ? probe_i[i] : la_data_in_i[i]. LA bits >= PROBE_BW are ignored.
- Reset values:
  - state IDLE; wr_cnt, rd_ptr, trig_cnt and div_cnt = 0.
  - Snapshot register and all buffer entries = 0.
  - done_o = 0.
- Trigger match: (probe_i & trig_mask_i) == (trig_value_i & trig_mask_i). A mask of all zeros matches on any cycle.
- State machine (2-bit encoding IDLE=0, ARMED=1, CAPTURE=2, DONE=3):
  - Any state + cfg_arm_i -> ARMED next cycle. Clears wr_cnt, rd_ptr, div_cnt; buffer contents are retained.
  - ARMED + match -> CAPTURE. That same edge:
    - writes probe_i to snapshot and to mem[0];
    - sets wr_cnt = 1;
    - latches cfg_div_i into div_q;
    - increments trig_cnt (16-bit, saturates at 0xFFFF).
  - A match is not evaluated in the cycle cfg_arm_i is high; evaluation starts the cycle after.
  - CAPTURE: div_cnt counts 0..div_q.
    - When div_cnt == div_q: write probe_i to mem[wr_cnt], increment wr_cnt, set div_cnt = 0.
    - Otherwise div_cnt increments.
    - When wr_cnt reaches DEPTH -> DONE.
  - With cfg_div_i = 0, entries are consecutive cycles. Capture of DEPTH entries completes DEPTH-1 cycles after the trigger edge.
  - Changes to cfg_div_i or the trigger inputs during CAPTURE have no effect.
  - DONE: holds until cfg_arm_i. Each cfg_rd_i advances rd_ptr (mod DEPTH, wraps DEPTH-1 -> 0).
  - cfg_rd_i outside DONE is ignored. cfg_arm_i together with cfg_rd_i: arm wins.
- la_data_out_o (combinational from registers/inputs, zero-padded to LA_BW):
  - LIVE: probe_i (before override).
  - FREEZE: snapshot.
  - TRACE: mem[rd_ptr].
  - STATUS: [1:0] state, [AW+2:2] wr_cnt, [2*AW+2:AW+3] rd_ptr, [2*AW+18:2*AW+3] trig_cnt, rest 0.
- Reset mid-capture: everything returns to reset values immediately, asynchronously.

Decomposition:
- Shared package dbg_pkg holds:
  - mode encodings (DBG_MODE_LIVE/FREEZE/TRACE/STATUS);
  - state encodings;
  - status-word field offsets as functions of AW;
  - default PROBE_BW = 119, LA_BW = 128, and probe bit-slice offsets (ctl 0, mic 1, dfe 9:2/10, aco 114:11/115/116, wrd 117/118).
- One sub-module: dbg_trace_buf, a DEPTH x PROBE_BW flop array with write port (we, waddr, wdata) and asynchronous read port (raddr) and reset-to-zero.
- FSM, decimation counter and LA mux live in dbg_trace.

Test Plan:
1. Override: la_oenb_i = all 1s, probe_i = random -> probe_o == probe_i. Then la_oenb_i[0] = 0 with la_data_in_i[0] = 1, probe_i[0] = 0 -> probe_o[0] = 1, other bits unchanged.
2. Basic trace: mask = 0x3 (bits 0,1), value = 0x1, div = 0, arm, then probe_i = counter starting 0x10 with bit0 = 1 at trigger -> DONE 15 cycles after trigger. TRACE reads with 16 cfg_rd_i pulses return 16 consecutive counter values; the 17th read wraps to entry 0.
3. Decimation: div = 3 -> entries are spaced 4 cycles apart. done_o rises 60 cycles after the trigger edge. STATUS shows state = 3, wr_cnt = 16, trig_cnt = 1.
4. FREEZE: after trigger on probe_i = 0x5A, probe changes -> la_data_out_o stays 0x5A in FREEZE while LIVE tracks probe_i.
5. Re-arm / simultaneity: cfg_arm_i with cfg_rd_i in DONE -> ARMED, rd_ptr = 0. A match in the arm cycle does not trigger; a match on the next cycle does. cfg_rd_i in ARMED leaves rd_ptr = 0.
6. Reset mid-capture: assert rst_n_i low at wr_cnt = 7 -> STATUS reads all zeros, buffer entries read 0, done_o = 0.
